// File: rtl/uart_tx_pkg.sv
// Shared UART frame definitions: FSM state encoding, parity modes, default oversampling
// and the counter-width helper used by the serializer.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  localparam int unsigned DEFAULT_OVERSAMPLE = 16;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART serializer: one frame per accepted byte (start, data LSB first, optional parity, stop),
// paced by the shared oversampling tick from the baud rate generator.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int unsigned STOP_TICKS = 16,
  parameter int unsigned PARITY     = PARITY_NONE
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_tick,
  input  logic                 i_tx_start,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_tx_done_tick
);

  localparam int unsigned S_MAX = (OVERSAMPLE > STOP_TICKS) ? OVERSAMPLE : STOP_TICKS;
  localparam int unsigned S_W   = cnt_width(S_MAX);
  localparam int unsigned B_W   = cnt_width(DATA_BITS);

  localparam logic [S_W-1:0] S_BIT_LAST  = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0] S_STOP_LAST = S_W'(STOP_TICKS - 1);
  localparam logic [B_W-1:0] B_LAST      = B_W'(DATA_BITS - 1);

  tx_state_e            r_state;
  tx_state_e            w_state_next;
  logic [S_W-1:0]       r_s;
  logic [S_W-1:0]       w_s_next;
  logic [B_W-1:0]       r_bit;
  logic [B_W-1:0]       w_bit_next;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_next;
  logic                 r_par;
  logic                 w_par_next;
  logic                 w_tx_next;
  logic                 w_busy_next;
  logic                 w_done_next;
  logic                 w_bit_end;
  logic                 w_stop_end;

  assign w_bit_end  = i_tick && (r_s == S_BIT_LAST);
  assign w_stop_end = i_tick && (r_s == S_STOP_LAST);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state        <= ST_IDLE;
      r_s            <= '0;
      r_bit          <= '0;
      r_shift        <= '0;
      r_par          <= 1'b0;
      o_tx           <= 1'b1;
      o_busy         <= 1'b0;
      o_tx_done_tick <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_s            <= w_s_next;
      r_bit          <= w_bit_next;
      r_shift        <= w_shift_next;
      r_par          <= w_par_next;
      o_tx           <= w_tx_next;
      o_busy         <= w_busy_next;
      o_tx_done_tick <= w_done_next;
    end
  end

  // Next state and datapath; line/busy are decoded from the next state so they register in step.
  always_comb begin
    w_state_next = r_state;
    w_s_next     = r_s;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_par_next   = r_par;
    w_done_next  = 1'b0;
    w_tx_next    = 1'b1;
    w_busy_next  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_tx_start) begin
          w_state_next = ST_START;
          w_shift_next = i_data;
          w_par_next   = (PARITY == PARITY_ODD) ? ~^i_data : ^i_data;
          w_s_next     = '0;
          w_bit_next   = '0;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_s_next     = '0;
          w_state_next = ST_DATA;
        end else if (i_tick) begin
          w_s_next = r_s + S_W'(1);
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_s_next     = '0;
          w_shift_next = r_shift >> 1;
          if (r_bit == B_LAST) begin
            w_bit_next   = '0;
            w_state_next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            w_bit_next = r_bit + B_W'(1);
          end
        end else if (i_tick) begin
          w_s_next = r_s + S_W'(1);
        end
      end
      ST_PARITY: begin
        if (w_bit_end) begin
          w_s_next     = '0;
          w_state_next = ST_STOP;
        end else if (i_tick) begin
          w_s_next = r_s + S_W'(1);
        end
      end
      ST_STOP: begin
        if (w_stop_end) begin
          w_s_next     = '0;
          w_state_next = ST_IDLE;
          w_done_next  = 1'b1;
        end else if (i_tick) begin
          w_s_next = r_s + S_W'(1);
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    w_busy_next = (w_state_next != ST_IDLE);
    case (w_state_next)
      ST_START:  w_tx_next = 1'b0;
      ST_DATA:   w_tx_next = w_shift_next[0];
      ST_PARITY: w_tx_next = w_par_next;
      default:   w_tx_next = 1'b1;
    endcase
  end

endmodule
